// File: rtl/msg_stream_pkg.sv
// Shared types and message ROM for the message stream arbiter.
// Entry 0 carries the default "Hello, World!" banner; entry 3 is deliberately empty.
package msg_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT_ACK,
        DONE,
        ABORT
    } state_t;

    localparam int ROM_SRC = 8;
    localparam int ROM_LEN = 16;

    localparam logic [7:0] MSG_ROM [ROM_SRC][ROM_LEN] = '{
        '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20, 8'h57,
          8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h00, 8'h00, 8'h00},
        '{0: 8'h41, 1: 8'h42, 2: 8'h43, default: 8'h00},
        '{0: 8'h54, 1: 8'h78, 2: 8'h2d, 3: 8'h32, default: 8'h00},
        '{default: 8'h00},
        '{0: 8'h53, 1: 8'h34, default: 8'h00},
        '{0: 8'h53, 1: 8'h35, default: 8'h00},
        '{0: 8'h53, 1: 8'h36, default: 8'h00},
        '{0: 8'h53, 1: 8'h37, default: 8'h00}
    };

    localparam int MSG_LEN [ROM_SRC] = '{13, 3, 4, 0, 2, 2, 2, 2};

    function automatic logic [7:0] rom_byte(input int src, input int idx);
        if (src >= 0 && src < ROM_SRC && idx >= 0 && idx < ROM_LEN) begin
            return MSG_ROM[src][idx];
        end
        return 8'h00;
    endfunction

    function automatic int msg_len(input int src);
        if (src >= 0 && src < ROM_SRC) begin
            return MSG_LEN[src];
        end
        return 0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first pending requester at or after the pointer, wrapping.
// Purely combinational; the pointer register is owned by the caller.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] pending_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic               valid_o
);
    import msg_stream_pkg::*;

    logic [PTR_W-1:0] k;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        k       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            k = PTR_W'((int'(rr_ptr_i) + i) % NUM_SRC);
            if (!valid_o && pending_i[k]) begin
                grant_o[k] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Shares one Wishbone byte stream between NUM_SRC requesters; streams each
// granted source's ROM message one classic cycle per byte under a single CYC.
module msg_stream_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int MAX_LEN     = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] req_i,
    output logic [NUM_SRC-1:0] done_o,
    output logic [NUM_SRC-1:0] err_o,
    output logic               busy_o,
    output logic               cyc_o,
    output logic               stb_o,
    output logic [7:0]         dat_o,
    input  logic               stall_i,
    input  logic               ack_i
);
    import msg_stream_pkg::*;

    // state    | meaning
    // IDLE     | arbitrate pending requesters, load byte 0
    // STROBE   | stb_o high, waiting for !stall_i
    // WAIT_ACK | byte accepted, timer running until ack
    // DONE     | one-cycle done_o pulse, bus released
    // ABORT    | one-cycle err_o pulse, rest of message dropped

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SRC - 1);

    state_t               state_q,   state_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [PTR_W-1:0]     rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0]     src_q,     src_d;
    logic [NUM_SRC-1:0]   gnt_q,     gnt_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [IDX_W-1:0]     len_q,     len_d;
    logic [TMR_W-1:0]     timer_q,   timer_d;
    logic [7:0]           dat_q,     dat_d;

    logic [NUM_SRC-1:0]   arb_grant;
    logic                 arb_valid;
    logic [PTR_W-1:0]     win_idx;
    logic [IDX_W-1:0]     win_len;

    function automatic logic [IDX_W-1:0] src_len(input logic [PTR_W-1:0] src);
        int len;
        len = msg_len(int'(src));
        if (len > MAX_LEN) len = MAX_LEN;
        return IDX_W'(len);
    endfunction

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_grant[i]) win_idx = PTR_W'(i);
        end
    end

    assign win_len = src_len(win_idx);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req_i;
        rr_ptr_d  = rr_ptr_q;
        src_d     = src_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        len_d     = len_q;
        timer_d   = timer_q;
        dat_d     = dat_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    // A request from the winner in its own grant cycle is absorbed by the grant.
                    pending_d = (pending_q | req_i) & ~arb_grant;
                    gnt_d     = arb_grant;
                    src_d     = win_idx;
                    rr_ptr_d  = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
                    idx_d     = '0;
                    timer_d   = '0;
                    len_d     = win_len;
                    if (win_len == '0) begin
                        state_d = DONE;
                    end else begin
                        dat_d   = rom_byte(int'(win_idx), 0);
                        state_d = STROBE;
                    end
                end
            end
            STROBE: begin
                if (!stall_i) begin
                    timer_d = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_i) begin
                    if (idx_q == len_q - IDX_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        dat_d   = rom_byte(int'(src_q), int'(idx_q) + 1);
                        state_d = STROBE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            src_q     <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            timer_q   <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            src_q     <= src_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            timer_q   <= timer_d;
            dat_q     <= dat_d;
        end
    end

    assign cyc_o  = (state_q == STROBE) || (state_q == WAIT_ACK);
    assign stb_o  = (state_q == STROBE);
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE)  ? gnt_q : '0;
    assign err_o  = (state_q == ABORT) ? gnt_q : '0;
    assign dat_o  = dat_q;

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Scoreboard bench for msg_stream_arbiter: stimulus queues expected bytes and
// done/err pulses, an independent monitor pops and compares them.
module tb_msg_stream_arbiter;

    localparam int K_BYTE = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b1;
    logic [3:0] req_i   = '0;
    logic       stall_i = 1'b0;
    logic       ack_i   = 1'b0;
    logic [3:0] done_o;
    logic [3:0] err_o;
    logic       busy_o;
    logic       cyc_o;
    logic       stb_o;
    logic [7:0] dat_o;

    exp_t  expq[$];
    string msg_txt[4];
    int    n_tests = 0;
    int    n_fail  = 0;

    int stall_at = -1, drop_at = -1;
    int a_idx = 0, stall_seen = 0, stb_run = 0, stall_run = 0;
    int cyc_run = 0, last_cyc_run = 0, low_run = 0, last_gap = 0;
    int wait_run = 0, err_run = 0;

    always #5 clk_i = ~clk_i;

    msg_stream_arbiter #(
        .NUM_SRC     (4),
        .MAX_LEN     (16),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .done_o  (done_o),
        .err_o   (err_o),
        .busy_o  (busy_o),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .dat_o   (dat_o),
        .stall_i (stall_i),
        .ack_i   (ack_i)
    );

    function automatic string kname(input int k);
        case (k)
            K_BYTE:  return "byte";
            K_DONE:  return "done";
            default: return "err";
        endcase
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void sb_pop(input int kind, input logic [7:0] val);
        exp_t e;
        n_tests++;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_%s: got 0x%02h, nothing expected", kname(kind), val);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_fail++;
                $display("FAIL sb_%s: got %s 0x%02h, expected %s 0x%02h",
                         kname(kind), kname(kind), val, kname(e.kind), e.val);
            end
        end
    endfunction

    task automatic push_item(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        expq.push_back(e);
    endtask

    task automatic push_bytes(input int s, input int n);
        for (int i = 0; i < n; i++) push_item(K_BYTE, msg_txt[s][i]);
    endtask

    task automatic push_msg(input int s);
        push_bytes(s, msg_txt[s].len());
        push_item(K_DONE, 8'(1 << s));
    endtask

    task automatic pulse_req(input logic [3:0] m);
        @(posedge clk_i); #1;
        req_i = m;
        @(posedge clk_i); #1;
        req_i = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while ((expq.size() != 0 || busy_o) && c < budget) begin
            @(negedge clk_i); #1;
            c++;
        end
        n_tests++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL %s: timed out after %0d cycles, %0d items outstanding, busy %0b",
                     name, budget, expq.size(), busy_o);
        end
    endtask

    task automatic wait_done(input string name, input logic [3:0] m, input int budget);
        int c = 0;
        while (done_o != m && c < budget) begin
            @(negedge clk_i); #1;
            c++;
        end
        n_tests++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL %s: no done_o=%04b within %0d cycles", name, m, budget);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        expq.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Monitor: compares every accepted byte and every done/err pulse.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (cyc_o && stb_o && !stall_i) sb_pop(K_BYTE, dat_o);
            if (done_o != '0) sb_pop(K_DONE, {4'b0000, done_o});
            if (err_o != '0)  sb_pop(K_ERR,  {4'b0000, err_o});
        end
    end

    // FIFO model: acks one cycle after acceptance, optional stall/drop, bus timing stats.
    initial begin
        bit acc, give;
        forever begin
            @(negedge clk_i);
            acc  = rst_ni && cyc_o && stb_o && !stall_i;
            give = acc && (a_idx != drop_at);
            if (stb_o && stall_i) stall_seen++;
            if (stb_o) stb_run++;
            if (acc) begin
                if (a_idx == stall_at) stall_run = stb_run;
                stb_run = 0;
            end
            if (!stb_o) stb_run = 0;
            if (cyc_o) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
                cyc_run++;
            end else begin
                if (cyc_run > 0) last_cyc_run = cyc_run;
                cyc_run = 0;
                low_run++;
            end
            if (cyc_o && !stb_o) begin
                wait_run++;
            end else begin
                if (err_o != '0) err_run = wait_run;
                wait_run = 0;
            end
            if (!cyc_o) a_idx = 0;
            else if (acc) a_idx++;
            @(posedge clk_i); #1;
            ack_i   = give;
            stall_i = (stall_at >= 0) && (a_idx == stall_at) && (stall_seen < 5);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int c;
        msg_txt = '{"Hello, World!", "ABC", "Tx-2", ""};

        #3 rst_ni = 1'b0;
        #20;
        check("rst_bus", int'({cyc_o, stb_o, busy_o}), 0);
        check("rst_pulses", int'({done_o, err_o}), 0);
        check("rst_dat", int'(dat_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: single message, immediate acks
        push_msg(0);
        pulse_req(4'b0001);
        wait_drain("t1_drain", 200);
        check("t1_busy_after_done", int'(busy_o), 0);
        check("t1_cyc_high_cycles", last_cyc_run, 26);

        // 2: simultaneous requests served round-robin, then pointer back at 0
        do_reset();
        push_msg(0); push_msg(1); push_msg(3);
        pulse_req(4'b1011);
        wait_drain("t2_drain", 300);
        push_msg(0); push_msg(3);
        pulse_req(4'b1001);
        wait_drain("t2_rr_drain", 300);

        // 3: stall 5 cycles on byte 2
        stall_at = 2; stall_seen = 0;
        push_msg(0);
        pulse_req(4'b0001);
        wait_drain("t3_drain", 300);
        check("t3_stb_hold_cycles", stall_run, 6);
        check("t3_stall_cycles", stall_seen, 5);
        stall_at = -1;

        // 4: ack withheld on byte 4 -> abort, next pending source served
        drop_at = 4;
        push_bytes(0, 5);
        push_item(K_ERR, 8'h01);
        push_msg(2);
        pulse_req(4'b0001);
        repeat (4) @(posedge clk_i);
        pulse_req(4'b0100);
        wait_drain("t4_drain", 400);
        check("t4_timeout_cycles", err_run, 64);
        drop_at = -1;

        // 5: asynchronous reset in the middle of byte 6
        push_bytes(0, 7);
        pulse_req(4'b0001);
        pulse_req(4'b0010);
        c = 0;
        while (!(stb_o && a_idx == 7) && c < 100) begin
            @(negedge clk_i); #1;
            c++;
        end
        check("t5_reach_byte6", int'(c < 100), 1);
        #1 rst_ni = 1'b0;
        #1;
        check("t5_async_bus_low", int'({cyc_o, stb_o, busy_o}), 0);
        check("t5_sb_consumed", expq.size(), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        busy_cnt = 0;
        repeat (12) begin
            @(negedge clk_i); #1;
            if (busy_o || cyc_o) busy_cnt++;
        end
        check("t5_pending_cleared", busy_cnt, 0);
        push_msg(0);
        pulse_req(4'b0001);
        wait_drain("t5_restart_drain", 200);

        // 6: held request repeats, a second requester is served between repeats
        push_msg(0); push_msg(0); push_msg(2); push_msg(0);
        @(negedge clk_i); #1;
        req_i = 4'b0001;
        wait_done("t6_first_done", 4'b0001, 200);
        repeat (3) @(negedge clk_i);
        #1 req_i = 4'b0101;
        @(negedge clk_i);
        #1 req_i = 4'b0001;
        @(negedge clk_i); #1;
        wait_done("t6_second_done", 4'b0001, 200);
        check("t6_cyc_gap_in_range", int'(last_gap >= 1 && last_gap <= 2), 1);
        wait_done("t6_fair_done", 4'b0100, 200);
        req_i = 4'b0000;
        wait_drain("t6_drain", 300);

        check("final_sb_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
